prog_boot_sequencer: RTL
========================

Name: prog_boot_sequencer

Overview:
- Boot and run controller for the single-cycle MIPS core.
- Loads a block of register-bank initial values through the core's init port (escribir / dirIniciar / EWIniciar while sel=0).
- Then hands the bank to the datapath (sel=1) and enables the PC for a bounded run.
- Ends the run on external halt, jump-to-self detection, or cycle timeout, then freezes the core and reports status.

Parameters:
START_REG, 1, first bank address written during init (register 0 skipped by default)
MAX_CYCLES, 1024, RUN-state cycle limit before timeout (≥2)
SELF_LOOP_CYC, 2, consecutive cycles with addresNext unchanged that signal a halt (≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; starts a sequence from IDLE or DONE
init_count  in  6  number of words to load (0..32); sampled on accepted start
init_data  in  32  init word from source
init_valid  in  1  init word available
init_ready  out  1  sequencer accepts init_data this cycle
escribir  out  32  bank write data (init mode)
dirIniciar  out  5  bank write address (init mode)
EWIniciar  out  1  bank write enable (init mode)
sel  out  1  0 = init port drives bank; 1 = datapath drives bank
run_en  out  1  PC update enable to core
addresNext  in  32  core next-PC value
halt_req  in  1  external stop request
busy  out  1  high in INIT, SETTLE, RUN
done  out  1  high in DONE
halt_cause  out  2  00 none, 01 halt_req, 10 self-loop, 11 timeout
cycle_cnt  out  32  RUN cycles executed in current/last run

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state): state=IDLE; escribir=0, dirIniciar=0, EWIniciar=0, sel=0, run_en=0, init_ready=0, busy=0, done=0, halt_cause=00, cycle_cnt=0. Reset takes effect mid-write or mid-run without waiting for the clock; deassertion is sampled on the next clk edge.
- States: IDLE, INIT, WRITE, SETTLE, RUN, DONE.
- IDLE / DONE, on start:
  - Latch init_count; addr := START_REG; clear cycle_cnt and halt_cause.
  - Next state is INIT if init_count>0, else SETTLE.
  - done falls on the same edge.
  - start is ignored in INIT/WRITE/SETTLE/RUN.
- INIT: init_ready=1, EWIniciar=0.
  - On init_valid&&init_ready: escribir := init_data, dirIniciar := addr, go WRITE.
- WRITE (1 cycle): EWIniciar=1, init_ready=0; escribir/dirIniciar held stable.
  - Decrement remaining count; addr := addr+1, wrapping modulo 32.
  - If remaining count reaches 0, go SETTLE, else INIT.
  - escribir/dirIniciar never change in the cycle EWIniciar falls, so the bank write is glitch-free.
  - Peak throughput: one word per 2 cycles.
- SETTLE (1 cycle): EWIniciar=0, sel=0, run_en=0; next RUN.
- RUN: sel=1, run_en=1, busy=1; cycle_cnt increments every cycle.
  - Self-loop detector: compares addresNext with its value from the previous cycle; a run counter resets on any mismatch.
  - Exit priority, evaluated each cycle:
    1. halt_req → cause 01
    2. addresNext unchanged for SELF_LOOP_CYC consecutive cycles → cause 10
    3. cycle_cnt = MAX_CYCLES-1 → cause 11
  - On exit, go DONE on the next edge with cycle_cnt frozen at its value including the exit cycle.
  - Simultaneous conditions: the lowest priority number wins.
- DONE: sel=0, EWIniciar=0, run_en=0 (bank and PC frozen); done=1, busy=0; halt_cause and cycle_cnt held until the next start.
- init_valid without init_ready is ignored; the source holds data until accepted.
- init_count values above 32 are clamped to 32.
- cycle_cnt never wraps because MAX_CYCLES bounds it.

Test Plan:
1. Reset mid-INIT (after 2 of 4 words): assert rst_n=0 asynchronously → all outputs zero immediately; IDLE; no further EWIniciar.
2. start with init_count=3, data 0x11,0x22,0x33 always valid → EWIniciar pulses at addresses 1,2,3 with matching data, each pulse one cycle with data stable one cycle after; sel rises 2 cycles after the last pulse.
3. init_count=0 → INIT skipped; SETTLE one cycle, then sel=1, run_en=1.
4. RUN with addresNext 0x0,0x4,0x8,0x8,0x8 (jump-to-self) → DONE with halt_cause=10, run_en=0, sel=0, cycle_cnt=4.
5. RUN with incrementing addresNext, MAX_CYCLES=16 → DONE with halt_cause=11, cycle_cnt=16; the same cycle with halt_req=1 and the self-loop condition also true → halt_cause=01.
6. start pulse during RUN → ignored. start in DONE → new sequence; done=0 next cycle, cycle_cnt cleared to 0.

Source files
------------

// File: rtl/prog_boot_sequencer.sv
// Boot and run controller for the single-cycle MIPS core.
// Loads initial register-bank values through the core init port, then
// hands the bank to the datapath and runs the PC until halt_req, a
// jump-to-self, or a cycle timeout ends the run. All outputs are registered.
module prog_boot_sequencer #(
    parameter int unsigned START_REG     = 1,
    parameter int unsigned MAX_CYCLES    = 1024,
    parameter int unsigned SELF_LOOP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  init_count,
    input  logic [31:0] init_data,
    input  logic        init_valid,
    output logic        init_ready,
    output logic [31:0] escribir,
    output logic [4:0]  dirIniciar,
    output logic        EWIniciar,
    output logic        sel,
    output logic        run_en,
    input  logic [31:0] addresNext,
    input  logic        halt_req,
    output logic        busy,
    output logic        done,
    output logic [1:0]  halt_cause,
    output logic [31:0] cycle_cnt
);

    localparam int unsigned LW         = $clog2(SELF_LOOP_CYC + 1);
    localparam logic [4:0]    START_ADDR = 5'(START_REG);
    localparam logic [31:0]   LAST_CYCLE = 32'(MAX_CYCLES - 1);
    localparam logic [LW-1:0] LOOP_LAST  = LW'(SELF_LOOP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    remain_q, remain_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   escribir_q, escribir_d;
    logic [4:0]    dir_q, dir_d;
    logic          ew_q, ew_d;
    logic          sel_q, sel_d;
    logic          run_en_q, run_en_d;
    logic          init_ready_q, init_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    cause_q, cause_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   prev_pc_q, prev_pc_d;
    logic [LW-1:0] loop_q, loop_d;
    logic [5:0]    count_clamp_s;
    logic          pc_match_s;
    logic          self_loop_s;
    logic          timeout_s;

    // Clamp requested word count and evaluate the run-exit conditions.
    always_comb begin
        count_clamp_s = (init_count > 6'd32) ? 6'd32 : init_count;
        // loop_q == 0 marks the first RUN cycle: no valid previous PC yet.
        pc_match_s    = (loop_q != '0) && (addresNext == prev_pc_q);
        self_loop_s   = pc_match_s && (loop_q == LOOP_LAST);
        timeout_s     = (cycle_q == LAST_CYCLE);
    end

    // Next-state and next-output logic; outputs are decoded from the next state.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        escribir_d = escribir_q;
        dir_d      = dir_q;
        cause_d    = cause_q;
        cycle_d    = cycle_q;
        prev_pc_d  = addresNext;
        loop_d     = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    remain_d = count_clamp_s;
                    addr_d   = START_ADDR;
                    cycle_d  = 32'd0;
                    cause_d  = 2'b00;
                    state_d  = (count_clamp_s != 6'd0) ? ST_INIT : ST_SETTLE;
                end else begin
                    state_d  = state_q;
                end
            end
            ST_INIT: begin
                if (init_valid && init_ready_q) begin
                    escribir_d = init_data;
                    dir_d      = addr_q;
                    state_d    = ST_WRITE;
                end else begin
                    state_d    = ST_INIT;
                end
            end
            ST_WRITE: begin
                // escribir/dirIniciar stay put so the falling EWIniciar edge is clean.
                remain_d = remain_q - 6'd1;
                addr_d   = addr_q + 5'd1;
                state_d  = (remain_q == 6'd1) ? ST_SETTLE : ST_INIT;
            end
            ST_SETTLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cycle_d = cycle_q + 32'd1;
                loop_d  = pc_match_s ? (loop_q + LW'(1)) : LW'(1);
                if (halt_req) begin
                    cause_d = 2'b01;
                    state_d = ST_DONE;
                end else if (self_loop_s) begin
                    cause_d = 2'b10;
                    state_d = ST_DONE;
                end else if (timeout_s) begin
                    cause_d = 2'b11;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ew_d         = (state_d == ST_WRITE);
        init_ready_d = (state_d == ST_INIT);
        sel_d        = (state_d == ST_RUN);
        run_en_d     = (state_d == ST_RUN);
        busy_d       = (state_d == ST_INIT) || (state_d == ST_WRITE) ||
                       (state_d == ST_SETTLE) || (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
    end

    // State, datapath and registered-output flops with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remain_q     <= 6'd0;
            addr_q       <= 5'd0;
            escribir_q   <= 32'd0;
            dir_q        <= 5'd0;
            ew_q         <= 1'b0;
            sel_q        <= 1'b0;
            run_en_q     <= 1'b0;
            init_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cause_q      <= 2'b00;
            cycle_q      <= 32'd0;
            prev_pc_q    <= 32'd0;
            loop_q       <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            addr_q       <= addr_d;
            escribir_q   <= escribir_d;
            dir_q        <= dir_d;
            ew_q         <= ew_d;
            sel_q        <= sel_d;
            run_en_q     <= run_en_d;
            init_ready_q <= init_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cause_q      <= cause_d;
            cycle_q      <= cycle_d;
            prev_pc_q    <= prev_pc_d;
            loop_q       <= loop_d;
        end
    end

    assign init_ready = init_ready_q;
    assign escribir   = escribir_q;
    assign dirIniciar = dir_q;
    assign EWIniciar  = ew_q;
    assign sel        = sel_q;
    assign run_en     = run_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign halt_cause = cause_q;
    assign cycle_cnt  = cycle_q;

endmodule
